// File: rtl/readout_input_framer.sv
// ---------------------------------------------------------------------------
// readout_input_framer
//
// Collects a trace of NUM_SAMPLES signed ADC samples. Each sample is
// quantized to Q_BITS bits and packed into one flat vector for the
// first-layer neuron inputs. A complete trace is held on m_data with
// m_valid=1 until the consumer takes it. Traces that are too short or too
// long are dropped, and a one-cycle error pulse is raised.
//
// Optional feature macro: READOUT_FRAMER_ERRCNT_EN
//   When defined, adds saturating 16-bit counters of short and long traces.
//
// Ports
//   clk       : single clock; all logic runs on its rising edge
//   rst       : synchronous, active-high reset
//   s_data    : signed input sample (SAMPLE_W bits)
//   s_valid   : input sample valid
//   s_ready   : framer can accept a sample
//   s_last    : marks the final sample of a trace
//   m_data    : packed frame; sample 0 sits in the LSBs
//   m_valid   : frame valid (registered)
//   m_ready   : downstream accepts the frame
//   err_short : one-cycle pulse, trace ended early
//   err_long  : one-cycle pulse, trace ran past NUM_SAMPLES
//   short_cnt : (ERRCNT_EN only) number of short traces, saturating
//   long_cnt  : (ERRCNT_EN only) number of long traces, saturating
// ---------------------------------------------------------------------------
module readout_input_framer #(
  parameter int SAMPLE_W    = 16,
  parameter int NUM_SAMPLES = 32,
  parameter int Q_BITS      = 2,
  parameter int SHIFT       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [SAMPLE_W-1:0]    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_last,
  output logic [NUM_SAMPLES*Q_BITS-1:0] m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          err_short,
  output logic                          err_long
`ifdef READOUT_FRAMER_ERRCNT_EN
  ,
  output logic [15:0]                   short_cnt,
  output logic [15:0]                   long_cnt
`endif
);

  localparam int CW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SAMPLES - 1);
  localparam logic signed [SAMPLE_W:0] Q_OFFSET = (SAMPLE_W+1)'(2**(Q_BITS-1));
  localparam logic signed [SAMPLE_W:0] Q_MAX    = (SAMPLE_W+1)'(2**Q_BITS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                          r_state;
  logic [CW-1:0]                   r_cnt;
  logic [NUM_SAMPLES*Q_BITS-1:0]   r_data;
  logic                            r_mValid;
  logic                            r_errShort;
  logic                            r_errLong;
`ifdef READOUT_FRAMER_ERRCNT_EN
  logic [15:0]                     r_shortCnt;
  logic [15:0]                     r_longCnt;
`endif

  logic                            w_accept;
  logic signed [SAMPLE_W-1:0]      w_shifted;
  logic signed [SAMPLE_W:0]        w_ext;
  logic signed [SAMPLE_W:0]        w_sum;
  logic [Q_BITS-1:0]               w_q;

  // s_ready is forced low during reset so no sample is taken while the
  // framer is being cleared; otherwise only HOLD back-pressures.
  assign s_ready  = !rst && (r_state != HOLD);
  assign w_accept = s_valid && s_ready;

  // Floor shift, then offset into unsigned range. One extra bit of headroom
  // keeps the offset add from wrapping before saturation.
  assign w_shifted = s_data >>> SHIFT;
  assign w_ext     = {w_shifted[SAMPLE_W-1], w_shifted};
  assign w_sum     = w_ext + Q_OFFSET;

  always_comb begin
    w_q = w_sum[Q_BITS-1:0];
    if (w_sum[SAMPLE_W]) begin
      w_q = '0;
    end else if (w_sum > Q_MAX) begin
      w_q = '1;
    end
  end

  // Main FSM. Outputs are all registered. An error pulse is set on the same
  // edge that decides the trace is bad, so it shows up the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_cnt      <= '0;
      r_data     <= '0;
      r_mValid   <= 1'b0;
      r_errShort <= 1'b0;
      r_errLong  <= 1'b0;
`ifdef READOUT_FRAMER_ERRCNT_EN
      r_shortCnt <= '0;
      r_longCnt  <= '0;
`endif
    end else begin
      r_errShort <= 1'b0;
      r_errLong  <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_data[r_cnt*Q_BITS +: Q_BITS] <= w_q;
            if (r_cnt == LAST_IDX) begin
              r_cnt <= '0;
              if (s_last) begin
                r_state  <= HOLD;
                r_mValid <= 1'b1;
              end else begin
                r_state   <= DISCARD;
                r_errLong <= 1'b1;
`ifdef READOUT_FRAMER_ERRCNT_EN
                if (r_longCnt != 16'hFFFF) r_longCnt <= r_longCnt + 16'd1;
`endif
              end
            end else if (s_last) begin
              r_cnt      <= '0;
              r_errShort <= 1'b1;
`ifdef READOUT_FRAMER_ERRCNT_EN
              if (r_shortCnt != 16'hFFFF) r_shortCnt <= r_shortCnt + 16'd1;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DISCARD: begin
          // Drop the overrun tail silently until the trace closes.
          if (w_accept && s_last) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
          end
        end
        HOLD: begin
          if (m_ready) begin
            r_state  <= COLLECT;
            r_cnt    <= '0;
            r_mValid <= 1'b0;
          end
        end
        default: begin
          r_state <= COLLECT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign m_data    = r_data;
  assign m_valid   = r_mValid;
  assign err_short = r_errShort;
  assign err_long  = r_errLong;
`ifdef READOUT_FRAMER_ERRCNT_EN
  assign short_cnt = r_shortCnt;
  assign long_cnt  = r_longCnt;
`endif

endmodule

// File: tb/tb_readout_input_framer.sv
// ---------------------------------------------------------------------------
// tb_readout_input_framer
//
// Directed testbench for readout_input_framer with NUM_SAMPLES=4, Q_BITS=2,
// SHIFT=4, SAMPLE_W=16. Expected frames are worked out by hand from the
// quantizer rule q = sat((x >>> 4) + 2, 0..3).
// ---------------------------------------------------------------------------
module tb_readout_input_framer;

  localparam int SAMPLE_W    = 16;
  localparam int NUM_SAMPLES = 4;
  localparam int Q_BITS      = 2;
  localparam int SHIFT       = 4;

  logic                          clk;
  logic                          rst;
  logic signed [SAMPLE_W-1:0]    s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic                          s_last;
  logic [NUM_SAMPLES*Q_BITS-1:0] m_data;
  logic                          m_valid;
  logic                          m_ready;
  logic                          err_short;
  logic                          err_long;
`ifdef READOUT_FRAMER_ERRCNT_EN
  logic [15:0]                   short_cnt;
  logic [15:0]                   long_cnt;
`endif

  int testsRun;
  int testsFailed;

  readout_input_framer #(
    .SAMPLE_W(SAMPLE_W),
    .NUM_SAMPLES(NUM_SAMPLES),
    .Q_BITS(Q_BITS),
    .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_last(s_last),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .err_short(err_short),
    .err_long(err_long)
`ifdef READOUT_FRAMER_ERRCNT_EN
    ,
    .short_cnt(short_cnt),
    .long_cnt(long_cnt)
`endif
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log misses.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one sample for a single clock edge; returns 1 ns after the edge.
  task automatic applyStimulus(input logic signed [SAMPLE_W-1:0] d, input logic l);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Send a full 4-sample trace with s_last on the final one.
  task automatic sendTrace(input logic signed [SAMPLE_W-1:0] d0,
                           input logic signed [SAMPLE_W-1:0] d1,
                           input logic signed [SAMPLE_W-1:0] d2,
                           input logic signed [SAMPLE_W-1:0] d3);
    applyStimulus(d0, 1'b0);
    applyStimulus(d1, 1'b0);
    applyStimulus(d2, 1'b0);
    applyStimulus(d3, 1'b1);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_err_short", err_short, 0);
    checkOutput("rst_err_long", err_long, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_s_ready", s_ready, 1);

    // Basic frame: q = 2,1,3,3 -> 8'hF6, then one HOLD bubble
    sendTrace(16'sd0, -16'sd16, 16'sd16, 16'sd40);
    checkOutput("basic_m_valid", m_valid, 1);
    checkOutput("basic_m_data", m_data, 8'hF6);
    checkOutput("basic_hold_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("basic_m_valid_fall", m_valid, 0);
    checkOutput("basic_back_collect", s_ready, 1);

    // Saturation: q = 0,0,3,3 -> 8'hF0
    sendTrace(-16'sd40, -16'sd40, 16'sd40, 16'sd40);
    checkOutput("sat_m_valid", m_valid, 1);
    checkOutput("sat_m_data", m_data, 8'hF0);
    @(posedge clk);
    #1;
    checkOutput("sat_m_valid_fall", m_valid, 0);

    // Short trace: s_last on the 2nd sample
    applyStimulus(16'sd16, 1'b0);
    applyStimulus(16'sd16, 1'b1);
    checkOutput("short_err_short", err_short, 1);
    checkOutput("short_err_long", err_long, 0);
    checkOutput("short_m_valid", m_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("short_pulse_end", err_short, 0);
    checkOutput("short_m_valid_late", m_valid, 0);
    // Frame after short: q = 3,2,1,0 -> 00 01 10 11 = 8'h1B
    sendTrace(16'sd16, 16'sd0, -16'sd16, -16'sd32);
    checkOutput("after_short_m_valid", m_valid, 1);
    checkOutput("after_short_m_data", m_data, 8'h1B);
    @(posedge clk);
    #1;

    // Long trace: six samples, s_last on the 6th
    applyStimulus(16'sd0, 1'b0);
    applyStimulus(16'sd0, 1'b0);
    applyStimulus(16'sd0, 1'b0);
    applyStimulus(16'sd0, 1'b0);
    checkOutput("long_err_long", err_long, 1);
    checkOutput("long_err_short", err_short, 0);
    checkOutput("long_m_valid", m_valid, 0);
    checkOutput("long_discard_ready", s_ready, 1);
    applyStimulus(16'sd40, 1'b0);
    checkOutput("long_no_second_pulse", err_long, 0);
    applyStimulus(16'sd40, 1'b1);
    checkOutput("long_tail_err_long", err_long, 0);
    checkOutput("long_tail_m_valid", m_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("long_after_m_valid", m_valid, 0);
`ifdef READOUT_FRAMER_ERRCNT_EN
    checkOutput("short_cnt", short_cnt, 1);
    checkOutput("long_cnt", long_cnt, 1);
`endif
    // Frame after long: basic vector again
    sendTrace(16'sd0, -16'sd16, 16'sd16, 16'sd40);
    checkOutput("after_long_m_data", m_data, 8'hF6);
    checkOutput("after_long_m_valid", m_valid, 1);
    @(posedge clk);
    #1;

    // Back-pressure: q = 3,0,2,1 -> 01 10 00 11 = 8'h63, held 10 cycles
    m_ready = 1'b0;
    sendTrace(16'sd32, -16'sd32, 16'sd0, -16'sd1);
    s_data  = 16'sd40;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("hold_m_valid_%0d", i), m_valid, 1);
      checkOutput($sformatf("hold_s_ready_%0d", i), s_ready, 0);
      checkOutput($sformatf("hold_m_data_%0d", i), m_data, 8'h63);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("hold_release_m_valid", m_valid, 0);
    checkOutput("hold_release_s_ready", s_ready, 1);

    // Reset after two samples discards the partial frame silently
    applyStimulus(16'sd40, 1'b0);
    applyStimulus(16'sd40, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_s_ready", s_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("midrst_m_data", m_data, 0);
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_err_short", err_short, 0);
    checkOutput("midrst_err_long", err_long, 0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_s_ready_after", s_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("midrst_no_err_short", err_short, 0);
    checkOutput("midrst_no_err_long", err_long, 0);
    sendTrace(-16'sd40, -16'sd40, 16'sd40, 16'sd40);
    checkOutput("after_rst_m_valid", m_valid, 1);
    checkOutput("after_rst_m_data", m_data, 8'hF0);
    @(posedge clk);
    #1;
    checkOutput("after_rst_m_valid_fall", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/readout_input_framer.md
READOUT_INPUT_FRAMER -- requirements
Module: readout_input_framer

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: signed ADC sample width.
REQ-002 SHALL have parameter NUM_SAMPLES, default 32: samples per readout trace (>=2).
REQ-003 SHALL have parameter Q_BITS, default 2: quantized bits per sample.
REQ-004 SHALL have parameter SHIFT, default 4: arithmetic right-shift applied before quantization.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port s_data, input, SAMPLE_W: signed sample.
REQ-008 SHALL have port s_valid, input, 1 and port s_ready, output, 1: sample handshake.
REQ-009 SHALL have port s_last, input, 1: marks the final sample of a trace.
REQ-010 SHALL have port m_data, output, NUM_SAMPLES*Q_BITS: flat vector feeding the first-layer neuron inputs.
REQ-011 SHALL have port m_valid, input-to-downstream output, 1 and port m_ready, input, 1: frame handshake.
REQ-012 SHALL have ports err_short and err_long, output, 1 each: one-cycle error pulses.

Function
REQ-013 SHALL accept a sample only on a cycle where s_valid and s_ready are both 1.
REQ-014 SHALL quantize: t = s_data >>> SHIFT (floor); q = t + 2^(Q_BITS-1), saturated to [0, 2^Q_BITS-1].
REQ-015 SHALL store the quantized sample at index cnt in m_data bits [cnt*Q_BITS +: Q_BITS]; sample 0 at LSBs.
REQ-016 SHALL implement states COLLECT, HOLD, DISCARD; s_ready=1 in COLLECT and DISCARD, 0 in HOLD.
REQ-017 COLLECT: each accepted sample increments cnt; accepted s_last with cnt==NUM_SAMPLES-1 -> HOLD.
REQ-018 COLLECT: accepted s_last with cnt<NUM_SAMPLES-1 -> frame dropped, err_short=1 next cycle, cnt=0, stay COLLECT.
REQ-019 COLLECT: accepted sample with cnt==NUM_SAMPLES-1 and s_last=0 -> err_long=1 next cycle, DISCARD.
REQ-020 DISCARD: accept and drop samples; accepted s_last -> COLLECT, cnt=0; no second err_long pulse.
REQ-021 HOLD: m_valid=1, m_data stable; on m_ready=1 -> COLLECT, cnt=0, m_valid=0 next cycle.
REQ-022 m_valid SHALL rise the cycle after the accepting edge of the final sample (latency 1); m_valid SHALL be registered, never combinational from inputs.
REQ-023 SHALL never alter m_data while m_valid=1; m_data between frames is don't-care except after reset.
REQ-024 Sustained throughput SHALL be NUM_SAMPLES+1 cycles per frame with m_ready held 1 (one bubble in HOLD).
REQ-025 err_short and err_long SHALL be single-cycle pulses, never simultaneous.

Reset
REQ-026 rst=1 SHALL force state COLLECT, cnt=0, m_data=0, m_valid=0, err_short=0, err_long=0 on the next edge.
REQ-027 s_ready SHALL be 0 while rst=1 and 1 the first cycle after rst deasserts.
REQ-028 rst mid-frame or in HOLD SHALL discard the partial/pending frame without any error pulse.

Configuration
REQ-029 With READOUT_FRAMER_ERRCNT_EN defined, SHALL add outputs short_cnt and long_cnt (16 bits each), incremented on each err_short/err_long pulse, saturating at 0xFFFF, cleared by rst.
REQ-030 Without READOUT_FRAMER_ERRCNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification (bench params: NUM_SAMPLES=4, Q_BITS=2, SHIFT=4, SAMPLE_W=16)
REQ-031 Samples 0,-16,16,40 with s_last on 4th, m_ready=1 -> m_valid one cycle after 4th accept, m_data=8'hF6, then COLLECT.
REQ-032 Saturation: samples -40,-40,40,40 (last on 4th) -> m_data=8'hF0.
REQ-033 s_last on 2nd sample -> err_short pulse one cycle, no m_valid; next full 4-sample trace framed correctly.
REQ-034 Six samples, s_last on 6th -> err_long one pulse after 4th accept, samples 5-6 dropped, no m_valid.
REQ-035 m_ready=0 for 10 cycles in HOLD -> s_ready=0, m_data stable throughout; m_ready=1 -> m_valid falls next cycle.
REQ-036 rst asserted after 2 samples -> all outputs reset, no error pulse; next full trace framed correctly; with READOUT_FRAMER_ERRCNT_EN, REQ-033/034 leave short_cnt=1, long_cnt=1.
